// File: rtl/core_branch_predict.sv
// Next-PC unit: direct-mapped BTB with saturating direction counters.
// Ports: fetch PC/pc4 in, redirect sources in, EX resolution in; next_pc/flush/prediction/stats out.
module core_branch_predict #(
  parameter int XLEN      = 64,
  parameter int ENTRIES   = 16,
  parameter int TAG_BITS  = 8,
  parameter int CTR_BITS  = 2,
  parameter int STAT_BITS = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 stall,
  input  logic [XLEN-1:0]      if_pc,
  input  logic [XLEN-1:0]      pc4,
  input  logic                 take_handler,
  input  logic [XLEN-1:0]      handler_addr,
  input  logic [XLEN-1:0]      epc,
  input  logic                 id_eret,
  input  logic                 id_jump,
  input  logic [XLEN-1:0]      id_jump_target,
  input  logic                 id_jr,
  input  logic [XLEN-1:0]      id_jr_target,
  input  logic                 ex_branch,
  input  logic [XLEN-1:0]      ex_pc,
  input  logic                 ex_taken,
  input  logic [XLEN-1:0]      ex_target,
  input  logic                 ex_pred_taken,
  input  logic [XLEN-1:0]      ex_pred_target,
  output logic [XLEN-1:0]      next_pc,
  output logic                 flush,
  output logic                 pred_taken,
  output logic [XLEN-1:0]      pred_target,
  output logic [STAT_BITS-1:0] branch_count,
  output logic [STAT_BITS-1:0] mispredict_count
);

  localparam int IDX = $clog2(ENTRIES);

  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_MIN = '0;
  localparam logic [CTR_BITS-1:0] CTR_WEAK =
    CTR_BITS'(1) << (CTR_BITS - 1);

  logic                vld_q [ENTRIES];
  logic [TAG_BITS-1:0] tag_q [ENTRIES];
  logic [XLEN-1:0]     tgt_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q [ENTRIES];

  logic [STAT_BITS-1:0] br_cnt_q;
  logic [STAT_BITS-1:0] mis_cnt_q;

  logic [IDX-1:0]      if_idx;
  logic [TAG_BITS-1:0] if_tag;
  logic                if_hit;

  logic [IDX-1:0]      ex_idx;
  logic [TAG_BITS-1:0] ex_tag;
  logic                ex_hit;
  logic [XLEN-1:0]     ex_pc4;
  logic [XLEN-1:0]     ex_fix_pc;
  logic                mis;
  logic                train;

  logic [CTR_BITS-1:0] ctr_cur;
  logic [CTR_BITS-1:0] ctr_nxt;

  logic [6:0] sel;

  // Only index/tag bits of the PCs feed the BTB.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc, ex_pc};

  // Fetch-side lookup
  assign if_idx = if_pc[IDX+1:2];
  assign if_tag = if_pc[IDX+2 +: TAG_BITS];
  assign if_hit = vld_q[if_idx] &
                  (tag_q[if_idx] == if_tag);

  assign pred_taken  = if_hit &
                       ctr_q[if_idx][CTR_BITS-1];
  assign pred_target = if_hit ? tgt_q[if_idx] : pc4;

  // EX-side resolution
  assign ex_idx = ex_pc[IDX+1:2];
  assign ex_tag = ex_pc[IDX+2 +: TAG_BITS];
  assign ex_hit = vld_q[ex_idx] &
                  (tag_q[ex_idx] == ex_tag);

  assign ex_pc4    = ex_pc + XLEN'(4);
  assign ex_fix_pc = ex_taken ? ex_target : ex_pc4;

  assign mis = ex_branch &
               ((ex_taken != ex_pred_taken) |
                (ex_taken &
                 (ex_target != ex_pred_target)));

  assign train = ex_branch & ~stall;

  // Saturating counter step
  assign ctr_cur = ctr_q[ex_idx];

  always_comb begin
    ctr_nxt = ctr_cur;
    if (ex_taken) begin
      if (ctr_cur != CTR_MAX)
        ctr_nxt = ctr_cur + CTR_BITS'(1);
    end else begin
      if (ctr_cur != CTR_MIN)
        ctr_nxt = ctr_cur - CTR_BITS'(1);
    end
  end

  // Redirect priority, encoded one-hot
  always_comb begin
    sel = '0;
    if (take_handler)   sel[0] = 1'b1;
    else if (id_eret)   sel[1] = 1'b1;
    else if (mis)       sel[2] = 1'b1;
    else if (id_jump)   sel[3] = 1'b1;
    else if (id_jr)     sel[4] = 1'b1;
    else if (pred_taken) sel[5] = 1'b1;
    else                sel[6] = 1'b1;
  end

  always_comb begin
    next_pc = pc4;
    flush   = 1'b0;
    unique case (1'b1)
      sel[0]: begin
        next_pc = handler_addr;
        flush   = 1'b1;
      end
      sel[1]: begin
        next_pc = epc;
        flush   = 1'b1;
      end
      sel[2]: begin
        next_pc = ex_fix_pc;
        flush   = 1'b1;
      end
      sel[3]: begin
        next_pc = id_jump_target;
        flush   = 1'b1;
      end
      sel[4]: begin
        next_pc = id_jr_target;
        flush   = 1'b1;
      end
      sel[5]: begin
        next_pc = pred_target;
        flush   = 1'b0;
      end
      sel[6]: begin
        next_pc = pc4;
        flush   = 1'b0;
      end
      default: begin
        next_pc = pc4;
        flush   = 1'b0;
      end
    endcase
  end

  // BTB training; a lookup this cycle still sees old contents
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        vld_q[i] <= 1'b0;
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= '0;
      end
    end else if (train) begin
      if (ex_hit) begin
        ctr_q[ex_idx] <= ctr_nxt;
        if (ex_taken)
          tgt_q[ex_idx] <= ex_target;
      end else if (ex_taken) begin
        vld_q[ex_idx] <= 1'b1;
        tag_q[ex_idx] <= ex_tag;
        tgt_q[ex_idx] <= ex_target;
        ctr_q[ex_idx] <= CTR_WEAK;
      end
    end
  end

  // Statistics, saturating at all-ones
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else if (train) begin
      if (~&br_cnt_q)
        br_cnt_q <= br_cnt_q + STAT_BITS'(1);
      if (mis && ~&mis_cnt_q)
        mis_cnt_q <= mis_cnt_q + STAT_BITS'(1);
    end
  end

  assign branch_count     = br_cnt_q;
  assign mispredict_count = mis_cnt_q;

endmodule
